// File: rtl/sram_bus_ctrl_if.sv
// Pipeline-side and SRAM-pin signal bundle for sram_bus_ctrl.
// The controller uses the slave modport; the pipeline/board side uses master.
interface sram_bus_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_data_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_o;
  logic              if_ce_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_data_o;
  logic              flush_i;
  logic              stallreq_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_data_o;
  logic [31:0]       sram_data_i;
  logic              sram_data_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    output mem_data_o,
    input  if_ce_i, if_addr_i,
    output if_data_o,
    input  flush_i,
    output stallreq_o,
    output sram_addr_o, sram_data_o, sram_data_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    input  sram_data_i
  );

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    input  mem_data_o,
    output if_ce_i, if_addr_i,
    input  if_data_o,
    output flush_i,
    input  stallreq_o,
    input  sram_addr_o, sram_data_o, sram_data_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    output sram_data_i
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// IF/MEM arbiter and multi-cycle asynchronous SRAM access sequencer with stall request.
// Optional one-entry fetch buffer enabled by defining SRAM_BUS_IF_BUF_EN.
module sram_bus_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input logic             clk,
  input logic             rst,
  sram_bus_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              src_mem;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic              data_oe;
  logic [3:0]        be_n;
  logic [31:0]       mem_rd;
  logic [31:0]       if_rd;
  logic              stall;
  logic              buf_hit;
  logic              take_req;
  logic              unused_bits;

  assign unused_bits = ^{bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0],
                         bus.if_addr_i[31:ADDR_W+2], bus.if_addr_i[1:0]};

  assign take_req = !bus.flush_i && (bus.mem_ce_i || (bus.if_ce_i && !buf_hit));

  // Stall request: any pending request in IDLE, whole ACCESS except a flushed write.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = take_req;
      ACCESS:  stall = !(bus.flush_i && we_q);
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Access sequencer; strobes are computed for the next state so they come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      src_mem <= 1'b0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      data_oe <= 1'b0;
      be_n    <= 4'b1111;
      mem_rd  <= 32'd0;
      if_rd   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take_req) begin
            state <= ACCESS;
            cnt   <= WAIT_INIT;
            ce_n  <= 1'b0;
            if (bus.mem_ce_i) begin
              addr_q  <= bus.mem_addr_i[ADDR_W+1:2];
              wdata_q <= bus.mem_data_i;
              we_q    <= bus.mem_we_i;
              src_mem <= 1'b1;
              oe_n    <= bus.mem_we_i;
              we_n    <= !bus.mem_we_i;
              data_oe <= bus.mem_we_i;
              be_n    <= bus.mem_we_i ? ~bus.mem_sel_i : 4'b0000;
            end else begin
              addr_q  <= bus.if_addr_i[ADDR_W+1:2];
              we_q    <= 1'b0;
              src_mem <= 1'b0;
              oe_n    <= 1'b0;
              we_n    <= 1'b1;
              data_oe <= 1'b0;
              be_n    <= 4'b0000;
            end
          end
        end
        ACCESS: begin
          if (bus.flush_i && !we_q) begin
            // Flushed reads abandon the access without touching the read registers.
            state   <= IDLE;
            cnt     <= 4'd0;
            ce_n    <= 1'b1;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            data_oe <= 1'b0;
            be_n    <= 4'b1111;
          end else if (cnt == 4'd0) begin
            state   <= DONE;
            ce_n    <= 1'b1;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            data_oe <= 1'b0;
            be_n    <= 4'b1111;
            if (!we_q && src_mem) begin
              mem_rd <= bus.sram_data_i;
            end else if (!we_q) begin
              if_rd <= bus.sram_data_i;
            end
          end else begin
            cnt  <= cnt - 4'd1;
            // The final ACCESS cycle (cnt reaches 0) is the write data-hold cycle.
            we_n <= !(we_q && (cnt != 4'd1));
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          cnt     <= 4'd0;
          ce_n    <= 1'b1;
          oe_n    <= 1'b1;
          we_n    <= 1'b1;
          data_oe <= 1'b0;
          be_n    <= 4'b1111;
        end
      endcase
    end
  end

`ifdef SRAM_BUS_IF_BUF_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_word;

  assign buf_hit = (state == IDLE) && bus.if_ce_i && buf_valid &&
                   (buf_addr == bus.if_addr_i[ADDR_W+1:2]);

  // Fetch buffer: refilled on every completed fetch, invalidated by a write to the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_word  <= 32'd0;
    end else if ((state == ACCESS) && (cnt == 4'd0) && !we_q && !src_mem && !bus.flush_i) begin
      buf_valid <= 1'b1;
      buf_addr  <= addr_q;
      buf_word  <= bus.sram_data_i;
    end else if ((state == DONE) && src_mem && we_q && (buf_addr == addr_q)) begin
      buf_valid <= 1'b0;
    end
  end

  assign bus.if_data_o = buf_hit ? buf_word : if_rd;
`else
  assign buf_hit       = 1'b0;
  assign bus.if_data_o = if_rd;
`endif

  assign bus.stallreq_o   = stall;
  assign bus.mem_data_o   = mem_rd;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_data_o  = wdata_q;
  assign bus.sram_data_oe = data_oe;
  assign bus.sram_ce_n    = ce_n;
  assign bus.sram_oe_n    = oe_n;
  assign bus.sram_we_n    = we_n;
  assign bus.sram_be_n    = be_n;
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl: stimulus queues expected access records,
// a negedge monitor rebuilds each SRAM access from the pins and compares.
module tb_sram_bus_ctrl;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sram_bus_ctrl_if #(.ADDR_W(20)) bif ();
  sram_bus_ctrl #(.WAIT_CYCLES(W), .ADDR_W(20)) dut (.clk(clk), .rst(rst), .bus(bif));

  logic [31:0] sram_mem [0:255];
  assign bif.sram_data_i = sram_mem[bif.sram_addr_o[7:0]];

  typedef struct {
    logic [19:0] addr;
    int          ce_cyc;
    int          we_cyc;
    int          oe_cyc;
    int          doe_cyc;
    logic [3:0]  be_n;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] mem_q;
    logic [31:0] if_q;
    int          stall_run;
    logic        last_we;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] exp_mem = 32'd0;
  logic [31:0] exp_if = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [19:0] a, input int ce, input int we, input int oe,
                              input int doe, input logic [3:0] be, input logic [31:0] wd,
                              input logic chk, input int run, input logic lwe);
    exp_t e;
    e.addr = a; e.ce_cyc = ce; e.we_cyc = we; e.oe_cyc = oe; e.doe_cyc = doe;
    e.be_n = be; e.wdata = wd; e.chk_wdata = chk; e.mem_q = exp_mem; e.if_q = exp_if;
    e.stall_run = run; e.last_we = lwe;
    return e;
  endfunction

  // Monitor state
  logic        in_acc = 1'b0;
  logic [19:0] c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_wd;
  logic        c_last_we;
  int ce_c, we_c, oe_c, doe_c;
  int run = 0;
  int last_run = 0;

  always @(negedge clk) begin
    if (bif.stallreq_o) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (!bif.sram_ce_n) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        c_addr = bif.sram_addr_o;
        c_be = bif.sram_be_n;
        c_wd = bif.sram_data_o;
        ce_c = 0; we_c = 0; oe_c = 0; doe_c = 0;
      end
      ce_c++;
      if (!bif.sram_we_n) we_c++;
      if (!bif.sram_oe_n) oe_c++;
      if (bif.sram_data_oe) doe_c++;
      c_last_we = bif.sram_we_n;
    end else if (in_acc) begin
      in_acc = 1'b0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_access: got addr %h expected none", c_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sram_addr", 32'(c_addr), 32'(e.addr));
        check("ce_cycles", 32'(ce_c), 32'(e.ce_cyc));
        check("we_cycles", 32'(we_c), 32'(e.we_cyc));
        check("oe_cycles", 32'(oe_c), 32'(e.oe_cyc));
        check("data_oe_cycles", 32'(doe_c), 32'(e.doe_cyc));
        check("be_n", 32'(c_be), 32'(e.be_n));
        check("last_we_n", 32'(c_last_we), 32'(e.last_we));
        check("stall_run", 32'(last_run), 32'(e.stall_run));
        check("mem_data_o", bif.mem_data_o, e.mem_q);
        check("if_data_o", bif.if_data_o, e.if_q);
        if (e.chk_wdata) check("sram_data_o", c_wd, e.wdata);
      end
    end
  end

  task automatic mem_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
    bif.mem_addr_i = a;
    bif.mem_data_i = d;
    bif.mem_sel_i = s;
    bif.mem_we_i = w;
    bif.mem_ce_i = 1'b1;
  endtask

  // Wait for the DONE cycle (stall low), then move just past the next rising edge.
  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bif.stallreq_o && n < 40);
    if (bif.stallreq_o) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got stall after %0d cycles expected done", nm, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
    sram_mem[0]  = 32'h3C08BFC0;
    sram_mem[1]  = 32'h24090001;
    sram_mem[4]  = 32'h12345678;
    sram_mem[12] = 32'hCAFEF00D;
    sram_mem[16] = 32'h55AA55AA;
    bif.mem_ce_i = 1'b0; bif.mem_we_i = 1'b0; bif.mem_addr_i = 32'd0;
    bif.mem_data_i = 32'd0; bif.mem_sel_i = 4'd0;
    bif.if_ce_i = 1'b0; bif.if_addr_i = 32'd0; bif.flush_i = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ce_n", 32'(bif.sram_ce_n), 32'd1);
    check("rst_oe_we_n", 32'({bif.sram_oe_n, bif.sram_we_n}), 32'd3);
    check("rst_be_n", 32'(bif.sram_be_n), 32'hF);
    check("rst_data_oe", 32'(bif.sram_data_oe), 32'd0);
    check("rst_addr", 32'(bif.sram_addr_o), 32'd0);
    check("rst_sram_data", bif.sram_data_o, 32'd0);
    check("rst_rdata", bif.mem_data_o | bif.if_data_o, 32'd0);
    check("rst_stall", 32'(bif.stallreq_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Word read
    exp_mem = 32'h12345678;
    exp_q.push_back(mk(20'h4, W+1, 0, W+1, 0, 4'b0000, 32'd0, 1'b0, W+2, 1'b1));
    mem_req(32'h80000010, 32'd0, 4'b1111, 1'b0);
    wait_done("read");
    bif.mem_ce_i = 1'b0;

    // Full-word write
    exp_q.push_back(mk(20'h8, W+1, W, 0, W+1, 4'b0000, 32'hDEADBEEF, 1'b1, W+2, 1'b1));
    mem_req(32'h80000020, 32'hDEADBEEF, 4'b1111, 1'b1);
    wait_done("write");
    bif.mem_ce_i = 1'b0;

    // Single-byte write
    exp_q.push_back(mk(20'h9, W+1, W, 0, W+1, 4'b1011, 32'h00AB0000, 1'b1, W+2, 1'b1));
    mem_req(32'h80000024, 32'h00AB0000, 4'b0100, 1'b1);
    wait_done("bytewrite");
    bif.mem_ce_i = 1'b0;

    // IF and MEM together: MEM first, IF right after MEM's DONE
    exp_mem = 32'hCAFEF00D;
    exp_q.push_back(mk(20'd12, W+1, 0, W+1, 0, 4'b0000, 32'd0, 1'b0, W+2, 1'b1));
    exp_if = 32'h24090001;
    exp_q.push_back(mk(20'd1, W+1, 0, W+1, 0, 4'b0000, 32'd0, 1'b0, W+2, 1'b1));
    bif.if_addr_i = 32'h80000004;
    bif.if_ce_i = 1'b1;
    mem_req(32'h80000030, 32'd0, 4'b1111, 1'b0);
    wait_done("contend_mem");
    bif.mem_ce_i = 1'b0;
    wait_done("contend_if");
    bif.if_ce_i = 1'b0;

    // Flush in the 2nd ACCESS cycle of a read: abort, load data unchanged
    exp_q.push_back(mk(20'd16, 2, 0, 2, 0, 4'b0000, 32'd0, 1'b0, 3, 1'b1));
    mem_req(32'h80000040, 32'd0, 4'b1111, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    bif.flush_i = 1'b1;
    @(posedge clk); #1;
    bif.flush_i = 1'b0;
    bif.mem_ce_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Same flush during a write: the write sequence still completes
    exp_q.push_back(mk(20'd20, W+1, W, 0, W+1, 4'b0000, 32'h11112222, 1'b1, W-1, 1'b1));
    mem_req(32'h80000050, 32'h11112222, 4'b1111, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    bif.flush_i = 1'b1;
    @(negedge clk);
    check("flush_write_stall", 32'(bif.stallreq_o), 32'd0);
    @(posedge clk); #1;
    bif.flush_i = 1'b0;
    bif.mem_ce_i = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;

    // Instruction fetch
    exp_if = 32'h3C08BFC0;
    exp_q.push_back(mk(20'd0, W+1, 0, W+1, 0, 4'b0000, 32'd0, 1'b0, W+2, 1'b1));
    bif.if_addr_i = 32'h80000000;
    bif.if_ce_i = 1'b1;
    wait_done("fetch");
    bif.if_ce_i = 1'b0;
`ifdef SRAM_BUS_IF_BUF_EN
    @(posedge clk); #1;
    bif.if_ce_i = 1'b1;
    @(negedge clk);
    check("buf_hit_stall", 32'(bif.stallreq_o), 32'd0);
    check("buf_hit_data", bif.if_data_o, 32'h3C08BFC0);
    @(posedge clk); #1;
    check("buf_hit_no_access", 32'(bif.sram_ce_n), 32'd1);
    bif.if_ce_i = 1'b0;
`endif

    // Reset in the middle of a write releases everything at once
    exp_mem = 32'd0;
    exp_if = 32'd0;
    exp_q.push_back(mk(20'd24, 2, 2, 0, 2, 4'b0000, 32'hA5A5A5A5, 1'b1, 3, 1'b0));
    mem_req(32'h80000060, 32'hA5A5A5A5, 4'b1111, 1'b1);
    @(posedge clk); @(posedge clk); @(negedge clk); #2;
    rst = 1'b1;
    bif.mem_ce_i = 1'b0;
    #1;
    check("rst_mid_ce_n", 32'(bif.sram_ce_n), 32'd1);
    check("rst_mid_we_n", 32'(bif.sram_we_n), 32'd1);
    check("rst_mid_stall", 32'(bif.stallreq_o), 32'd0);
    check("rst_mid_data_oe", 32'(bif.sram_data_oe), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_bus_ctrl.md
# sram_bus_ctrl

- Memory-side responder for the pipeline controller's store/stall handshake.
- Accepts instruction-fetch and MEM-stage requests, arbitrates them and runs multi-cycle accesses on the external 32-bit asynchronous SRAM.
- Returns `stallreq_o`, which feeds the controller's `stallreq_from_mem`.
- Sits between the IF/MEM stages and the board SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: access-phase wait states. Legal range 1..15.
- `ADDR_W`, default 20: SRAM word-address width.

Ports:
- `clk` in 1: single clock. All logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_ce_i` in 1: MEM-stage request.
- `mem_we_i` in 1: write qualifier. Driven by the controller's `mem_we_o`.
- `mem_addr_i` in 32: byte address.
- `mem_data_i` in 32: store data.
- `mem_sel_i` in 4: byte lanes, active-high.
- `mem_data_o` out 32: load data.
- `if_ce_i` in 1: instruction fetch request.
- `if_addr_i` in 32: fetch byte address.
- `if_data_o` out 32: fetched instruction.
- `flush_i` in 1: exception flush from the controller.
- `stallreq_o` out 1: stall request to the controller.
- `sram_addr_o` out ADDR_W: word address, equal to `addr[ADDR_W+1:2]`.
- `sram_data_o` out 32: write data.
- `sram_data_i` in 32: read data.
- `sram_data_oe` out 1: data bus output enable.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1: SRAM strobes, active-low.
- `sram_be_n` out 4: byte enables, active-low.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If `mem_ce_i` is high, latch the MEM request: address, data, sel, we, source=MEM.
  - Otherwise, if `if_ce_i` is high, latch the IF request as a read with source=IF.
  - MEM always wins over IF.
  - When a request is latched, go to ACCESS and load counter `cnt` with WAIT_CYCLES.
  - If `flush_i` is high in IDLE, no request is accepted.
- ACCESS:
  - `sram_ce_n` is low.
  - `sram_addr_o` is driven from the latched address.
  - `cnt` decrements each cycle. Leave for DONE when `cnt`==0, so ACCESS lasts WAIT_CYCLES+1 cycles.
- ACCESS, read:
  - `sram_oe_n` low and `sram_be_n`=0000.
  - `sram_data_i` is captured into the source's read register on the last ACCESS cycle.
- ACCESS, write:
  - `sram_data_oe` high for all ACCESS cycles.
  - `sram_be_n` = `~sel`.
  - `sram_we_n` is low in every ACCESS cycle except the last, which is the data-hold cycle.
- DONE:
  - One cycle, all strobes inactive.
  - `stallreq_o` low, so the pipeline advances at the end of this cycle.
  - Return to IDLE.
- Stall request:
  - `stallreq_o` is combinational.
  - High in IDLE when an unserved request is present and `flush_i` is low.
  - High throughout ACCESS.
  - Low in DONE.
- Loads are word-wide: `mem_data_o` always carries the full 32-bit word, and lane extraction is the MEM stage's job.
- Flush during ACCESS:
  - A read aborts to IDLE on the next edge and read registers keep their old value.
  - A write completes its ACCESS sequence, with `stallreq_o` forced low while `flush_i` is high.
- Outputs `mem_data_o` and `if_data_o` are registers. They hold their last value until overwritten.

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n`=1, `sram_be_n`=1111.
  - `sram_data_oe`=0, `sram_addr_o`=0, `sram_data_o`=0.
  - `mem_data_o`=0, `if_data_o`=0, `stallreq_o`=0.
- Reset asserted mid-access immediately releases all strobes, with no completion.
- Latency: a request seen in cycle 0 gives ACCESS in cycles 1..W+1 and DONE in cycle W+2. `stallreq_o` is high for W+2 cycles.
- Back-to-back requests:
  - A new request presented in the cycle after DONE starts normally.
  - Throughput is one access per W+3 cycles.
- Simultaneous IF and MEM requests: MEM is served first. IF stays stalled and is served starting in the IDLE cycle after MEM's DONE.
- Strobe outputs are registered from the state, so they are glitch-free.

## Configuration
- `SRAM_BUS_IF_BUF_EN` defined:
  - Adds a one-entry fetch buffer (valid, address, word), filled on every IF read completion.
  - An IF request in IDLE whose address matches a valid entry returns `if_data_o` in the same cycle (combinational) with `stallreq_o` low, and no SRAM access.
  - Any MEM write to a matching word address clears valid at write DONE. Reset clears valid.
- Undefined: every IF request goes to SRAM.

## Test plan
- Read with W=1: `mem_ce_i`=1, `mem_we_i`=0, addr 0x80000010, SRAM returns 0x12345678 -> `sram_addr_o`=0x00004, `sram_oe_n` low 2 cycles, `stallreq_o` high 3 cycles, `mem_data_o`=0x12345678 in DONE.
- Write with W=1: addr 0x80000020, data 0xDEADBEEF, sel 1111 -> `sram_addr_o`=0x00008, `sram_we_n` low exactly 1 cycle, `sram_be_n`=0000, `sram_data_oe` high 2 cycles.
- Byte write: sel 0100 -> `sram_be_n`=1011 during ACCESS.
- Contention: `if_ce_i` and `mem_ce_i` both asserted in the same cycle -> MEM access first, IF access starts immediately after, `stallreq_o` high continuously except in the two DONE cycles.
- Flush mid-read, W=3: `flush_i` pulsed in the 2nd ACCESS cycle -> IDLE on next edge, `mem_data_o` unchanged. Same pulse during a write -> `sram_we_n` sequence completes.
- `rst` asserted in the middle of a write -> `sram_we_n`, `sram_ce_n`, `stallreq_o` deassert within the same cycle. With `SRAM_BUS_IF_BUF_EN`, a repeated fetch of 0x80000000 returns in 0 stall cycles.
